// File: rtl/coprocessor_io_pkg.sv
// Shared definitions for the coprocessor I/O controller: register map, CTRL/STATUS bit
// positions and the transaction FSM states.
package coprocessor_io_pkg;

   localparam logic [2:0] ADDR_OP_LO  = 3'd0;
   localparam logic [2:0] ADDR_OP_HI  = 3'd1;
   localparam logic [2:0] ADDR_CTRL   = 3'd2;
   localparam logic [2:0] ADDR_STATUS = 3'd3;
   localparam logic [2:0] ADDR_RES_LO = 3'd4;
   localparam logic [2:0] ADDR_RES_HI = 3'd5;

   localparam int CTRL_START   = 0;
   localparam int CTRL_ABORT   = 1;
   localparam int CTRL_OPC_LSB = 4;

   localparam int STAT_BUSY    = 0;
   localparam int STAT_DONE    = 1;
   localparam int STAT_TIMEOUT = 2;
   localparam int STAT_IRQ_EN  = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

endpackage

// File: rtl/coprocessor_io_regfile.sv
// Avalon-MM register file for the coprocessor I/O controller: write decode, registered read
// mux, operand/result storage and W1C status flags. Optional irq via COPROC_IO_CTRL_IRQ_EN.
module coprocessor_io_regfile
   import coprocessor_io_pkg::*;
#(
   parameter int OPCODE_W = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [2:0]          address,
   input  logic                chipselect,
   input  logic                write_n,
   input  logic [31:0]         writedata,
   output logic [31:0]         readdata,
   input  logic                busy,
   input  logic                start_ack,
   input  logic                set_done,
   input  logic                set_timeout,
   input  logic                res_load,
   input  logic [63:0]         res_in,
   output logic [63:0]         op,
   output logic                start_req,
   output logic                abort_req,
   output logic [OPCODE_W-1:0] opcode_req,
   output logic                done,
   output logic                timeout
`ifdef COPROC_IO_CTRL_IRQ_EN
   ,
   output logic                irq
`endif
);

   logic        wr_en;
   logic        ctrl_wr;
   logic        status_wr;
   logic        done_nxt;
   logic        timeout_nxt;
   logic        irq_en;
   logic        irq_en_nxt;
   logic [63:0] res;
   logic [31:0] status_word;
   logic [31:0] rd_mux;

   assign wr_en      = chipselect && !write_n;
   assign ctrl_wr    = wr_en && (address == ADDR_CTRL);
   assign status_wr  = wr_en && (address == ADDR_STATUS);
   assign start_req  = ctrl_wr && writedata[CTRL_START];
   assign abort_req  = ctrl_wr && writedata[CTRL_ABORT];
   assign opcode_req = writedata[CTRL_OPC_LSB +: OPCODE_W];

   // A set event in the same cycle as a W1C clear leaves the flag set.
   assign done_nxt    = set_done ||
                        (done && !(status_wr && writedata[STAT_DONE]) && !start_ack);
   assign timeout_nxt = set_timeout ||
                        (timeout && !(status_wr && writedata[STAT_TIMEOUT]) && !start_ack);

`ifdef COPROC_IO_CTRL_IRQ_EN
   assign irq_en_nxt = status_wr ? writedata[STAT_IRQ_EN] : irq_en;
`else
   assign irq_en_nxt = 1'b0;
`endif

   always_comb begin
      status_word               = '0;
      status_word[STAT_BUSY]    = busy;
      status_word[STAT_DONE]    = done;
      status_word[STAT_TIMEOUT] = timeout;
      status_word[STAT_IRQ_EN]  = irq_en;
   end

   always_comb begin
      rd_mux = '0;
      case (address)
         ADDR_OP_LO:  rd_mux = op[31:0];
         ADDR_OP_HI:  rd_mux = op[63:32];
         ADDR_STATUS: rd_mux = status_word;
         ADDR_RES_LO: rd_mux = res[31:0];
         ADDR_RES_HI: rd_mux = res[63:32];
         default:     rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         readdata <= '0;
         op       <= '0;
         res      <= '0;
         done     <= 1'b0;
         timeout  <= 1'b0;
         irq_en   <= 1'b0;
      end else begin
         readdata <= rd_mux;
         // Operand is frozen while a transaction is in flight.
         if (wr_en && !busy && (address == ADDR_OP_LO)) op[31:0]  <= writedata;
         if (wr_en && !busy && (address == ADDR_OP_HI)) op[63:32] <= writedata;
         if (res_load) res <= res_in;
         done    <= done_nxt;
         timeout <= timeout_nxt;
         irq_en  <= irq_en_nxt;
      end
   end

`ifdef COPROC_IO_CTRL_IRQ_EN
   // Built from next-state flags so irq tracks STATUS without an extra cycle of lag.
   always_ff @(posedge clk) begin
      if (reset) irq <= 1'b0;
      else       irq <= irq_en_nxt && (done_nxt || timeout_nxt);
   end
`endif

endmodule

// File: rtl/coprocessor_io_ctrl.sv
// Avalon-MM slave sequencing one 64-bit coprocessor transaction at a time: issue handshake,
// result wait and timeout. Define COPROC_IO_CTRL_IRQ_EN to add the irq output.
module coprocessor_io_ctrl
   import coprocessor_io_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int OPCODE_W       = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [2:0]          address,
   input  logic                chipselect,
   input  logic                write_n,
   input  logic [31:0]         writedata,
   output logic [31:0]         readdata,
   output logic [63:0]         cop_op,
   output logic [OPCODE_W-1:0] cop_opcode,
   output logic                cop_valid,
   input  logic                cop_ready,
   input  logic [63:0]         cop_res,
   input  logic                cop_res_valid,
   output logic                cop_res_ready
`ifdef COPROC_IO_CTRL_IRQ_EN
   ,
   output logic                irq
`endif
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
   localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic                busy;
   logic                start_req;
   logic                abort_req;
   logic [OPCODE_W-1:0] opcode_req;
   logic                start_ack;
   logic                to_hit;
   logic                set_done;
   logic                set_timeout;
   logic                done;
   logic                timeout;

   assign busy      = (state != IDLE);
   assign start_ack = (state == IDLE) && start_req && !abort_req;
   assign to_hit    = TO_EN && (cnt == CNT_LAST);
   // Abort beats everything; result acceptance beats timeout; in ISSUE timeout beats handshake.
   assign set_done    = (state == WAIT) && !abort_req && cop_res_valid;
   assign set_timeout = busy && !abort_req && to_hit && !set_done;

   coprocessor_io_regfile #(.OPCODE_W(OPCODE_W)) u_regfile (
      .clk         (clk),
      .reset       (reset),
      .address     (address),
      .chipselect  (chipselect),
      .write_n     (write_n),
      .writedata   (writedata),
      .readdata    (readdata),
      .busy        (busy),
      .start_ack   (start_ack),
      .set_done    (set_done),
      .set_timeout (set_timeout),
      .res_load    (set_done),
      .res_in      (cop_res),
      .op          (cop_op),
      .start_req   (start_req),
      .abort_req   (abort_req),
      .opcode_req  (opcode_req),
      .done        (done),
      .timeout     (timeout)
`ifdef COPROC_IO_CTRL_IRQ_EN
      ,
      .irq         (irq)
`endif
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         cnt           <= '0;
         cop_opcode    <= '0;
         cop_valid     <= 1'b0;
         cop_res_ready <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_ack) begin
                  state      <= ISSUE;
                  cop_opcode <= opcode_req;
                  cnt        <= '0;
                  cop_valid  <= 1'b1;
               end
            end
            ISSUE: begin
               cnt <= cnt + CNT_W'(1);
               if (abort_req || set_timeout) begin
                  state     <= IDLE;
                  cop_valid <= 1'b0;
               end else if (cop_ready) begin
                  state         <= WAIT;
                  cop_valid     <= 1'b0;
                  cop_res_ready <= 1'b1;
               end
            end
            WAIT: begin
               cnt <= cnt + CNT_W'(1);
               if (abort_req || set_done || set_timeout) begin
                  state         <= IDLE;
                  cop_res_ready <= 1'b0;
               end
            end
            default: begin
               state         <= IDLE;
               cop_valid     <= 1'b0;
               cop_res_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_coprocessor_io_ctrl.sv
// Self-checking bench for coprocessor_io_ctrl: register reads, full transaction, timeout,
// abort, busy-write protection and (with COPROC_IO_CTRL_IRQ_EN) the irq output.
`timescale 1ns/1ps
module tb_coprocessor_io_ctrl;

   localparam int TO = 16;
   localparam int OW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [2:0]    address;
   logic          chipselect;
   logic          write_n;
   logic [31:0]   writedata;
   logic [31:0]   readdata;
   logic [63:0]   cop_op;
   logic [OW-1:0] cop_opcode;
   logic          cop_valid;
   logic          cop_ready;
   logic [63:0]   cop_res;
   logic          cop_res_valid;
   logic          cop_res_ready;
`ifdef COPROC_IO_CTRL_IRQ_EN
   logic          irq;
`endif

   int n_vec = 0;
   int n_err = 0;
   logic [31:0]       rd_q[$];
   logic [OW+63:0]    cmd_q[$];

   coprocessor_io_ctrl #(.TIMEOUT_CYCLES(TO), .OPCODE_W(OW)) dut (
      .clk           (clk),
      .reset         (reset),
      .address       (address),
      .chipselect    (chipselect),
      .write_n       (write_n),
      .writedata     (writedata),
      .readdata      (readdata),
      .cop_op        (cop_op),
      .cop_opcode    (cop_opcode),
      .cop_valid     (cop_valid),
      .cop_ready     (cop_ready),
      .cop_res       (cop_res),
      .cop_res_valid (cop_res_valid),
      .cop_res_ready (cop_res_ready)
`ifdef COPROC_IO_CTRL_IRQ_EN
      ,
      .irq           (irq)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] d);
      address = a;
      tick();
      d = readdata;
   endtask

   task automatic test_reset();
      logic [31:0] d, exp;
      reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
      cop_ready = 1'b0; cop_res_valid = 1'b0; cop_res = '0;
      repeat (3) tick();
      reset = 1'b0;
      n_vec++;
      if ({cop_valid, cop_res_ready, cop_opcode, cop_op} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs got v=%b rr=%b opc=%h op=%h want all 0",
                  cop_valid, cop_res_ready, cop_opcode, cop_op);
      end
      for (int a = 0; a < 8; a++) rd_q.push_back(32'h0);
      for (int a = 0; a < 8; a++) begin
         rd(3'(a), d);
         exp = rd_q.pop_front();
         n_vec++;
         if (d !== exp) begin
            n_err++;
            $display("FAIL reset_read addr%0d got %h want %h", a, d, exp);
         end
      end
   endtask

   task automatic test_transaction();
      logic [31:0]    d, exp;
      logic [OW+63:0] cmd;
      wr(3'd0, 32'h89ABCDEF);
      wr(3'd1, 32'h01234567);
      cmd_q.push_back({4'h3, 64'h0123456789ABCDEF});
      wr(3'd2, 32'h31);
      cmd = cmd_q.pop_front();
      for (int c = 0; c < 4; c++) begin
         n_vec++;
         if ({cop_valid, cop_opcode, cop_op} !== {1'b1, cmd}) begin
            n_err++;
            $display("FAIL txn_issue cyc%0d got v=%b opc=%h op=%h want v=1 opc=%h op=%h",
                     c, cop_valid, cop_opcode, cop_op, cmd[OW+63:64], cmd[63:0]);
         end
         if (c == 3) cop_ready = 1'b1;
         tick();
      end
      cop_ready = 1'b0;
      n_vec++;
      if ({cop_valid, cop_res_ready} !== 2'b01) begin
         n_err++;
         $display("FAIL txn_wait got v=%b rr=%b want v=0 rr=1", cop_valid, cop_res_ready);
      end
      repeat (4) tick();
      cop_res = 64'hDEADBEEF_CAFEF00D;
      cop_res_valid = 1'b1;
      tick();
      cop_res_valid = 1'b0;
      rd_q.push_back(32'h2); rd_q.push_back(32'hCAFEF00D); rd_q.push_back(32'hDEADBEEF);
      for (int i = 0; i < 3; i++) begin
         rd(3'(3 + i), d);
         exp = rd_q.pop_front();
         n_vec++;
         if (d !== exp) begin
            n_err++;
            $display("FAIL txn_read addr%0d got %h want %h", 3 + i, d, exp);
         end
      end
   endtask

   task automatic test_timeout();
      logic [31:0] d, exp;
      int n;
      cop_ready = 1'b0;
      wr(3'd2, 32'h01);
      n = 0;
      while (cop_valid === 1'b1 && n < 40) begin
         tick();
         n++;
      end
      n_vec++;
      if (n !== TO) begin
         n_err++;
         $display("FAIL timeout_cycles got %0d want %0d", n, TO);
      end
      rd_q.push_back(32'h4); rd_q.push_back(32'hCAFEF00D); rd_q.push_back(32'hDEADBEEF);
      for (int i = 0; i < 3; i++) begin
         rd(3'(3 + i), d);
         exp = rd_q.pop_front();
         n_vec++;
         if (d !== exp) begin
            n_err++;
            $display("FAIL timeout_read addr%0d got %h want %h", 3 + i, d, exp);
         end
      end
   endtask

   task automatic test_abort();
      logic [31:0] d, exp;
      wr(3'd2, 32'h01);
      cop_ready = 1'b1;
      tick();
      cop_ready = 1'b0;
      n_vec++;
      if (cop_res_ready !== 1'b1) begin
         n_err++;
         $display("FAIL abort_enter_wait got rr=%b want 1", cop_res_ready);
      end
      wr(3'd2, 32'h02);
      n_vec++;
      if ({cop_valid, cop_res_ready} !== 2'b00) begin
         n_err++;
         $display("FAIL abort_busy_drop got v=%b rr=%b want 0 0", cop_valid, cop_res_ready);
      end
      cop_res = 64'h11111111_22222222;
      cop_res_valid = 1'b1;
      tick();
      cop_res_valid = 1'b0;
      wr(3'd2, 32'h03);
      n_vec++;
      if (cop_valid !== 1'b0) begin
         n_err++;
         $display("FAIL start_abort_idle got v=%b want 0", cop_valid);
      end
      rd_q.push_back(32'h0); rd_q.push_back(32'hCAFEF00D); rd_q.push_back(32'hDEADBEEF);
      for (int i = 0; i < 3; i++) begin
         rd(3'(3 + i), d);
         exp = rd_q.pop_front();
         n_vec++;
         if (d !== exp) begin
            n_err++;
            $display("FAIL abort_read addr%0d got %h want %h", 3 + i, d, exp);
         end
      end
   endtask

   task automatic test_busy_writes();
      logic [31:0]    d, exp;
      logic [OW+63:0] cmd;
      logic [2:0]     ra [6];
      ra[0] = 3'd3; ra[1] = 3'd4; ra[2] = 3'd5; ra[3] = 3'd0; ra[4] = 3'd1; ra[5] = 3'd2;
      cmd_q.push_back({4'h5, 64'h0123456789ABCDEF});
      wr(3'd2, 32'h51);
      wr(3'd0, 32'hFFFFFFFF);
      wr(3'd2, 32'h71);
      cmd = cmd_q.pop_front();
      n_vec++;
      if ({cop_valid, cop_opcode, cop_op} !== {1'b1, cmd}) begin
         n_err++;
         $display("FAIL busy_issue got v=%b opc=%h op=%h want v=1 opc=%h op=%h",
                  cop_valid, cop_opcode, cop_op, cmd[OW+63:64], cmd[63:0]);
      end
      cop_ready = 1'b1;
      tick();
      cop_ready = 1'b0;
      cop_res = 64'h00000001_00000002;
      cop_res_valid = 1'b1;
      tick();
      cop_res_valid = 1'b0;
      rd_q.push_back(32'h2); rd_q.push_back(32'h2); rd_q.push_back(32'h1);
      rd_q.push_back(32'h89ABCDEF); rd_q.push_back(32'h01234567); rd_q.push_back(32'h0);
      for (int i = 0; i < 6; i++) begin
         rd(ra[i], d);
         exp = rd_q.pop_front();
         n_vec++;
         if (d !== exp) begin
            n_err++;
            $display("FAIL busy_read addr%0d got %h want %h", ra[i], d, exp);
         end
      end
      wr(3'd3, 32'h2);
      rd_q.push_back(32'h0);
      rd(3'd3, d);
      exp = rd_q.pop_front();
      n_vec++;
      if (d !== exp) begin
         n_err++;
         $display("FAIL done_w1c got %h want %h", d, exp);
      end
   endtask

`ifdef COPROC_IO_CTRL_IRQ_EN
   task automatic test_irq();
      logic [31:0] d, exp;
      wr(3'd3, 32'h8);
      n_vec++;
      if (irq !== 1'b0) begin
         n_err++;
         $display("FAIL irq_idle got %b want 0", irq);
      end
      wr(3'd2, 32'h01);
      cop_ready = 1'b1;
      tick();
      cop_ready = 1'b0;
      cop_res = 64'h0;
      cop_res_valid = 1'b1;
      tick();
      cop_res_valid = 1'b0;
      n_vec++;
      if (irq !== 1'b1) begin
         n_err++;
         $display("FAIL irq_set got %b want 1", irq);
      end
      wr(3'd3, 32'hA);
      n_vec++;
      if (irq !== 1'b0) begin
         n_err++;
         $display("FAIL irq_clear got %b want 0", irq);
      end
      rd_q.push_back(32'h8);
      rd(3'd3, d);
      exp = rd_q.pop_front();
      n_vec++;
      if (d !== exp) begin
         n_err++;
         $display("FAIL irq_status got %h want %h", d, exp);
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog expired after %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_transaction();
      test_timeout();
      test_abort();
      test_busy_writes();
`ifdef COPROC_IO_CTRL_IRQ_EN
      test_irq();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/coprocessor_io_ctrl.md
Name: coprocessor_io_ctrl

Overview:
- Avalon-MM slave that sequences one 64-bit coprocessor transaction at a time for the Nios core.
- Software loads a 64-bit operand as two 32-bit halves and writes a command; the block then drives a valid/ready handshake to the coprocessor.
- The block waits for the result, latches the 64-bit result and reports done or timeout in a status register.
- It replaces ad-hoc PIO polling of the coprocessor data_high/data_low ports.

Parameters:
- TIMEOUT_CYCLES, 1024: cycles allowed from leaving IDLE to result; 0 disables the timeout.
- OPCODE_W, 4: width of the opcode field passed to the coprocessor.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- address  in  3  Avalon word address
- chipselect  in  1  Avalon select
- write_n  in  1  Avalon write strobe, active-low
- writedata  in  32  Avalon write data
- readdata  out  32  Avalon read data, registered
- cop_op  out  64  operand to coprocessor {OP_HI, OP_LO}
- cop_opcode  out  OPCODE_W  opcode to coprocessor
- cop_valid  out  1  command valid
- cop_ready  in  1  coprocessor accepts command
- cop_res  in  64  coprocessor result
- cop_res_valid  in  1  result valid
- cop_res_ready  out  1  controller ready for result

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on port reset. All registers and outputs are 0 on reset, FSM returns to IDLE, and an in-flight transaction is dropped.
- Register map (word address):
  - 0 OP_LO, RW.
  - 1 OP_HI, RW.
  - 2 CTRL, W: bit0 START, bit1 ABORT, bits[4+OPCODE_W-1:4] opcode. Reads as 0.
  - 3 STATUS: bit0 busy (R), bit1 done (W1C), bit2 timeout (W1C), bit3 irq_en (RW, only with the optional feature).
  - 4 RES_LO, R.
  - 5 RES_HI, R.
  - 6-7 read 0; writes ignored.
- Read path: readdata is registered every cycle from address, independent of chipselect. Read latency is 1 cycle.
- Write decode: a write is chipselect && !write_n.
- FSM states:
  - IDLE: busy=0. A write to CTRL with START=1 latches the opcode, clears done and timeout, and goes to ISSUE on the next edge.
  - ISSUE: cop_valid=1, with cop_op and cop_opcode held stable. When cop_valid && cop_ready, go to WAIT.
  - WAIT: cop_res_ready=1. When cop_res_valid, latch cop_res into RES_HI:RES_LO, set done=1 and go to IDLE.
- Timeout counter:
  - Clears on leaving IDLE and increments each cycle in ISSUE or WAIT.
  - When it reaches TIMEOUT_CYCLES (if nonzero), set timeout=1, go to IDLE and leave the result registers unchanged.
  - Result acceptance wins over timeout in the same cycle.
- ABORT write in ISSUE or WAIT: go to IDLE next edge; done and timeout stay 0.
  - ABORT wins over a same-cycle handshake completion.
  - ABORT in IDLE has no effect.
- START while busy is ignored. START and ABORT together in IDLE: ABORT wins, nothing starts.
- OP_LO/OP_HI writes while busy are ignored, so the operand stays stable for the whole transaction.
- W1C: writing 1 to done or timeout clears the bit. If a set event occurs in the same cycle as the clear, set wins.
- cop_res_valid outside WAIT is ignored and not latched.

Optional Feature:
- Macro: COPROC_IO_CTRL_IRQ_EN.
- Defined:
  - Adds output port irq (1 bit, reset 0).
  - irq is registered and equals irq_en && (done || timeout).
  - STATUS bit3 becomes RW.
- Undefined: no irq port; STATUS bit3 reads 0 and writes are ignored.

Decomposition:
- Package coprocessor_io_pkg holds:
  - register address constants (ADDR_OP_LO … ADDR_RES_HI);
  - CTRL and STATUS bit indices;
  - the FSM state enum (IDLE, ISSUE, WAIT).
- Sub-module coprocessor_io_regfile holds the Avalon decode, registered read mux and W1C logic. The FSM and timeout counter stay in the top level.

Test Plan:
- Reset, then read each address 0-7 -> readdata 0 in every case one cycle after the address is presented.
- OP_LO=0x89ABCDEF, OP_HI=0x01234567, CTRL=0x31. Coprocessor: ready after 3 cycles, result 0xDEADBEEF_CAFEF00D after 5 more. Required:
  - cop_op=0x0123456789ABCDEF and cop_opcode=3 while cop_valid is high;
  - RES_HI=0xDEADBEEF, RES_LO=0xCAFEF00D;
  - STATUS=0x2.
- TIMEOUT_CYCLES=16, cop_ready held 0, START -> timeout set exactly 16 cycles after leaving IDLE; STATUS=0x4; result registers unchanged.
- START, then ABORT while in WAIT -> busy drops next cycle; done=0; a later cop_res_valid is not latched.
- While busy, write OP_LO=0xFFFFFFFF and a second START -> cop_op and the transaction are unaffected. Write STATUS=0x2 after done -> done clears.
- With COPROC_IO_CTRL_IRQ_EN: set irq_en, complete a transaction -> irq=1. Write STATUS with bit1=1 and bit3 kept 1 -> irq=0 on the following cycle.
